// File: rtl/mips_gpio_bank_if.sv
// Datapath memory-bus view of the GPIO bank: address/data/strobes in, hit and read data out.
interface mips_gpio_bank_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  we_i;
  logic                  re_i;
  logic                  hit_o;
  logic [DATA_WIDTH-1:0] rdata_o;

  modport master (output addr_i, wdata_i, we_i, re_i, input hit_o, rdata_o);
  modport slave  (input addr_i, wdata_i, we_i, re_i, output hit_o, rdata_o);
endinterface

// File: rtl/mips_gpio_bank.sv
// Memory-mapped GPIO bank: NUM_PORTS ports of OUT/IN/EDGE/IEN registers with
// 2-flop input synchronisers, rising-edge capture and one combined interrupt.
module mips_gpio_bank #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           GPIO_WIDTH = 8,
  parameter int unsigned           NUM_PORTS  = 2,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  mips_gpio_bank_if.slave                 bus,
  input  logic [NUM_PORTS*GPIO_WIDTH-1:0] gpio_i,
  output logic [NUM_PORTS*GPIO_WIDTH-1:0] gpio_o,
  output logic                            irq_o
);

  localparam int unsigned           PW     = NUM_PORTS * GPIO_WIDTH;
  localparam int unsigned           IDXW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [DATA_WIDTH-1:0] WINDOW = DATA_WIDTH'(16 * NUM_PORTS);

  typedef enum logic [1:0] {
    REG_OUT  = 2'd0,
    REG_IN   = 2'd1,
    REG_EDGE = 2'd2,
    REG_IEN  = 2'd3
  } reg_e;

  logic [PW-1:0]         out_q, out_d, ien_q, ien_d, edge_q, edge_d;
  logic [PW-1:0]         sync1_q, sync2_q, prev_q, prev_d, rise, clr;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, offset;
  logic [1:0]            warm_q, warm_d;
  logic                  irq_q, irq_d, hit, wr_en, rd_en;
  logic [IDXW-1:0]       port_idx;
  logic [GPIO_WIDTH-1:0] wbits, rsel;
  reg_e                  reg_sel;

  // The lower-bound compare keeps addresses below BASE_ADDR from aliasing via underflow.
  assign offset   = bus.addr_i - BASE_ADDR;
  assign hit      = (bus.addr_i >= BASE_ADDR) && (offset < WINDOW);
  assign port_idx = offset[4 +: IDXW];
  assign reg_sel  = reg_e'(bus.addr_i[3:2]);
  assign wbits    = bus.wdata_i[GPIO_WIDTH-1:0];
  assign wr_en    = bus.we_i & hit;
  assign rd_en    = bus.re_i & hit;

  assign bus.hit_o   = hit;
  assign bus.rdata_o = rdata_q;
  assign gpio_o      = out_q;
  assign irq_o       = irq_q;

  if (GPIO_WIDTH < DATA_WIDTH) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata_i[DATA_WIDTH-1:GPIO_WIDTH];
  end

  always_comb begin
    out_d   = out_q;
    ien_d   = ien_q;
    clr     = '0;
    rdata_d = rdata_q;
    rsel    = '0;
    irq_d   = |(edge_q & ien_q);
    warm_d  = (warm_q != 2'd0) ? warm_q - 2'd1 : warm_q;
    rise    = (warm_q == 2'd0) ? (sync2_q & ~prev_q) : '0;
    // During warm-up prev tracks sync1 so it equals sync2 once warm-up ends;
    // pins already high at reset release then never look like a rising edge.
    prev_d  = (warm_q != 2'd0) ? sync1_q : sync2_q;

    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (port_idx == IDXW'(p)) begin
        unique case (reg_sel)
          REG_OUT:  rsel = out_q[p*GPIO_WIDTH +: GPIO_WIDTH];
          REG_IN:   rsel = sync2_q[p*GPIO_WIDTH +: GPIO_WIDTH];
          REG_EDGE: rsel = edge_q[p*GPIO_WIDTH +: GPIO_WIDTH];
          REG_IEN:  rsel = ien_q[p*GPIO_WIDTH +: GPIO_WIDTH];
        endcase
        if (wr_en) begin
          case (reg_sel)
            REG_OUT:  out_d[p*GPIO_WIDTH +: GPIO_WIDTH] = wbits;
            REG_EDGE: clr[p*GPIO_WIDTH +: GPIO_WIDTH]   = wbits;
            REG_IEN:  ien_d[p*GPIO_WIDTH +: GPIO_WIDTH] = wbits;
            default:  ;
          endcase
        end
      end
    end

    edge_d = (edge_q & ~clr) | rise;
    if (rd_en) rdata_d = DATA_WIDTH'(rsel);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      out_q   <= '0;
      ien_q   <= '0;
      edge_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
      warm_q  <= 2'd2;
    end else begin
      out_q   <= out_d;
      ien_q   <= ien_d;
      edge_q  <= edge_d;
      sync1_q <= gpio_i;
      sync2_q <= sync1_q;
      prev_q  <= prev_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
      warm_q  <= warm_d;
    end
  end

endmodule

// File: tb/tb_mips_gpio_bank.sv
// Directed bench for mips_gpio_bank: a pin-history model is compared against the DUT
// every cycle, with literal expectations at key points of each scenario.
module tb_mips_gpio_bank;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;
  int          checks = 0;
  int          errors = 0;

  mips_gpio_bank_if #(.DATA_WIDTH(32)) bus_if ();

  mips_gpio_bank #(
    .DATA_WIDTH(32),
    .GPIO_WIDTH(8),
    .NUM_PORTS (2),
    .BASE_ADDR (32'h1000_0000)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst_n),
    .bus    (bus_if),
    .gpio_i (gpio_in),
    .gpio_o (gpio_out),
    .irq_o  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    longint unsigned la;
    la = 64'(a);
    return (la >= 64'h1000_0000) && (la < 64'h1000_0000 + 64'd32);
  endfunction

  // Model: the register file after each edge, derived from the list of pin samples
  // taken since reset release. IN seen at edge n is sample n-2; an edge is recorded
  // only when comparing two real samples (n >= 4).
  logic [7:0]  m_out [2];
  logic [7:0]  m_ien [2];
  logic [7:0]  m_edge[2];
  logic [31:0] m_rdata;
  logic        m_irq;
  bit          m_valid = 0;
  logic [15:0] hist[$];

  initial begin
    int          n;
    int          p;
    logic [1:0]  r;
    logic [15:0] in_now, rise;
    logic [7:0]  clrv[2];
    logic        irq_next;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int q = 0; q < 2; q++) begin
          m_out[q] = '0; m_ien[q] = '0; m_edge[q] = '0;
        end
        m_rdata = '0;
        m_irq   = 1'b0;
        hist.delete();
      end else begin
        n        = hist.size() + 1;
        in_now   = (n >= 3) ? hist[n-3] : 16'h0;
        rise     = (n >= 4) ? (hist[n-3] & ~hist[n-4]) : 16'h0;
        p        = int'((bus_if.addr_i - BASE) >> 4);
        r        = bus_if.addr_i[3:2];
        irq_next = |((m_edge[0] & m_ien[0]) | (m_edge[1] & m_ien[1]));
        clrv[0]  = '0;
        clrv[1]  = '0;
        if (in_window(bus_if.addr_i) && bus_if.re_i) begin
          case (r)
            2'd0: m_rdata = {24'h0, m_out[p]};
            2'd1: m_rdata = {24'h0, in_now[p*8 +: 8]};
            2'd2: m_rdata = {24'h0, m_edge[p]};
            default: m_rdata = {24'h0, m_ien[p]};
          endcase
        end
        if (in_window(bus_if.addr_i) && bus_if.we_i) begin
          case (r)
            2'd0: m_out[p] = bus_if.wdata_i[7:0];
            2'd2: clrv[p]  = bus_if.wdata_i[7:0];
            2'd3: m_ien[p] = bus_if.wdata_i[7:0];
            default: ;
          endcase
        end
        for (int q = 0; q < 2; q++) m_edge[q] = (m_edge[q] & ~clrv[q]) | rise[q*8 +: 8];
        m_irq = irq_next;
        hist.push_back(gpio_in);
      end
      m_valid = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("cyc gpio_o", {16'h0, gpio_out}, {16'h0, m_out[1], m_out[0]});
        check("cyc rdata_o", bus_if.rdata_o, m_rdata);
        check("cyc irq_o", {31'h0, irq}, {31'h0, m_irq});
        check("cyc hit_o", {31'h0, bus_if.hit_o}, {31'h0, in_window(bus_if.addr_i)});
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.addr_i = a; bus_if.wdata_i = d; bus_if.we_i = 1'b1;
    tick(1);
    bus_if.we_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus_if.addr_i = a; bus_if.re_i = 1'b1;
    tick(1);
    bus_if.re_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    gpio_in = 16'hFFFF;
    bus_if.addr_i = '0; bus_if.wdata_i = '0; bus_if.we_i = 1'b0; bus_if.re_i = 1'b0;

    // Reset with all pins high through release
    tick(3);
    check("rst gpio_o", {16'h0, gpio_out}, 32'h0);
    check("rst rdata_o", bus_if.rdata_o, 32'h0);
    check("rst irq_o", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    tick(6);
    rd(BASE + 32'h08); check("warm edge p0", bus_if.rdata_o, 32'h0);
    rd(BASE + 32'h18); check("warm edge p1", bus_if.rdata_o, 32'h0);
    rd(BASE + 32'h04); check("in p0 high", bus_if.rdata_o, 32'h0000_00FF);

    // OUT writes, dropped upper bits, simultaneous write+read
    gpio_in = 16'h0000;
    tick(4);
    wr(BASE + 32'h00, 32'h0000_00A5);
    wr(BASE + 32'h10, 32'hFFFF_FF3C);
    check("gpio after writes", {16'h0, gpio_out}, 32'h0000_3CA5);
    rd(BASE + 32'h00); check("rd out p0", bus_if.rdata_o, 32'h0000_00A5);
    rd(BASE + 32'h10); check("rd out p1", bus_if.rdata_o, 32'h0000_003C);
    bus_if.addr_i = BASE; bus_if.wdata_i = 32'h77; bus_if.we_i = 1'b1; bus_if.re_i = 1'b1;
    tick(1);
    bus_if.we_i = 1'b0; bus_if.re_i = 1'b0;
    check("wr+rd old value", bus_if.rdata_o, 32'h0000_00A5);
    check("wr+rd gpio", {16'h0, gpio_out}, 32'h0000_3C77);

    // Port1 pins 0x00 -> 0x81: synchroniser latency and edge capture
    gpio_in = 16'h8100;
    rd(BASE + 32'h14);
    rd(BASE + 32'h14); check("in p1 too early", bus_if.rdata_o, 32'h0);
    rd(BASE + 32'h14); check("in p1 synced", bus_if.rdata_o, 32'h0000_0081);
    rd(BASE + 32'h18); check("edge p1", bus_if.rdata_o, 32'h0000_0081);
    wr(BASE + 32'h18, 32'hFF);
    rd(BASE + 32'h18); check("edge p1 cleared", bus_if.rdata_o, 32'h0);

    // Interrupt latency and clear
    wr(BASE + 32'h0C, 32'h01);
    gpio_in = 16'h8101;
    tick(3); check("irq before 4 clk", {31'h0, irq}, 32'h0);
    tick(1); check("irq at 4 clk", {31'h0, irq}, 32'h1);
    wr(BASE + 32'h08, 32'h01); check("irq held on clr edge", {31'h0, irq}, 32'h1);
    tick(1); check("irq dropped", {31'h0, irq}, 32'h0);

    // Clear and new rise on the same edge: set wins
    gpio_in = 16'h8100; tick(4);
    gpio_in = 16'h8101; tick(5);
    check("irq re-armed", {31'h0, irq}, 32'h1);
    gpio_in = 16'h8100; tick(4);
    gpio_in = 16'h8101; tick(2);
    wr(BASE + 32'h08, 32'h01);
    tick(1); check("irq set wins", {31'h0, irq}, 32'h1);
    rd(BASE + 32'h08); check("edge set wins", bus_if.rdata_o, 32'h0000_0001);

    // Window boundaries
    bus_if.addr_i = BASE + 32'h20; bus_if.re_i = 1'b1;
    #1 check("hit above window", {31'h0, bus_if.hit_o}, 32'h0);
    tick(1); bus_if.re_i = 1'b0;
    check("rdata held on miss", bus_if.rdata_o, 32'h0000_0001);
    bus_if.addr_i = 32'h0FFF_FFF0; bus_if.wdata_i = 32'hFF; bus_if.we_i = 1'b1;
    #1 check("hit below window", {31'h0, bus_if.hit_o}, 32'h0);
    tick(1); bus_if.we_i = 1'b0;
    check("gpio after miss write", {16'h0, gpio_out}, 32'h0000_3C77);
    rd(BASE + 32'h0C); check("ien p0 kept", bus_if.rdata_o, 32'h0000_0001);
    bus_if.addr_i = BASE + 32'h1C;
    #1 check("hit last word", {31'h0, bus_if.hit_o}, 32'h1);
    rd(BASE + 32'h1C); check("ien p1", bus_if.rdata_o, 32'h0);

    // Reset in the middle of a write aborts it
    bus_if.addr_i = BASE; bus_if.wdata_i = 32'h55; bus_if.we_i = 1'b1; rst_n = 1'b0;
    tick(1); bus_if.we_i = 1'b0;
    check("mid rst gpio_o", {16'h0, gpio_out}, 32'h0);
    check("mid rst irq_o", {31'h0, irq}, 32'h0);
    check("mid rst rdata_o", bus_if.rdata_o, 32'h0);
    tick(1); rst_n = 1'b1;
    tick(6);
    rd(BASE + 32'h08); check("post rst edge p0", bus_if.rdata_o, 32'h0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
